// File: rtl/prom_string_streamer_if.sv
// rtl/prom_string_streamer_if.sv - pROM read port and UART TX byte stream bundle
// master = sequencer side, slave = pROM + UART transmitter side.
interface prom_string_streamer_if #(
  parameter int ADDR_W = 4
);
  logic              rom_ce;
  logic              rom_oce;
  logic              rom_reset;
  logic [ADDR_W-1:0] rom_ad;
  logic [7:0]        rom_dout;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rom_ce, rom_oce, rom_reset, rom_ad, tx_data, tx_valid,
    input  rom_dout, tx_ready
  );

  modport slave (
    input  rom_ce, rom_oce, rom_reset, rom_ad, tx_data, tx_valid,
    output rom_dout, tx_ready
  );
endinterface

// File: rtl/prom_string_streamer.sv
// rtl/prom_string_streamer.sv - walks a pROM string table and streams each byte to UART TX
// One byte per ISSUE/LATCH/SEND pass; the pROM's 1-cycle read latency is absorbed in LATCH.
module prom_string_streamer #(
  parameter int ADDR_W     = 4,
  parameter int START_ADDR = 0,
  parameter int MSG_LEN    = 15,
  parameter int LOOP       = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  prom_string_streamer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, LATCH, SEND, FINISH} state_t;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(START_ADDR + MSG_LEN - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [7:0]        data_q, data_next;
  logic              valid_q, valid_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr    <= FIRST_ADDR;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      addr    <= addr_next;
      data_q  <= data_next;
      valid_q <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr;
    data_next  = data_q;
    valid_next = valid_q;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = ISSUE;
          addr_next  = FIRST_ADDR;
        end
      end
      ISSUE: begin
        state_next = abort ? IDLE : LATCH;
      end
      LATCH: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          data_next  = bus.rom_dout;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        // The offered byte is never withdrawn; abort only takes effect at the handshake.
        if (bus.tx_ready) begin
          valid_next = 1'b0;
          if (addr == LAST_ADDR || abort) begin
            state_next = FINISH;
          end else begin
            addr_next  = addr + ADDR_W'(1);
            state_next = ISSUE;
          end
        end
      end
      FINISH: begin
        valid_next = 1'b0;
        if (LOOP != 0 && !abort) begin
          state_next = ISSUE;
          addr_next  = FIRST_ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign bus.rom_ce    = (state == ISSUE);
  assign bus.rom_oce   = 1'b1;
  assign bus.rom_reset = 1'b0;
  assign bus.rom_ad    = addr;
  assign bus.tx_data   = data_q;
  assign bus.tx_valid  = valid_q;
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);
endmodule

// File: tb/tb_prom_string_streamer.sv
// tb/tb_prom_string_streamer.sv - scoreboard bench for prom_string_streamer
// Four instances: 0 = MSG_LEN 15, 1 = LOOP, 2 = MSG_LEN 16, 3 = MSG_LEN 1.
module tb_prom_string_streamer;
  logic            clk;
  logic            resetn;
  logic [3:0]      start, abort, rdy;
  logic [3:0]      busy, done, tv, rce, oce, rrst;
  logic [3:0][7:0] txd;
  logic [3:0][3:0] rad;
  logic [7:0]      rom_mem [16];
  logic [7:0]      exp_q [$];
  logic [7:0]      exp_b;
  int              hs_cnt [4];
  int              done_cnt [4];
  int              checks;
  int              failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int ML = (g == 2) ? 16 : (g == 3) ? 1 : 15;
    localparam int LP = (g == 1) ? 1 : 0;
    prom_string_streamer_if #(.ADDR_W(4)) bus ();
    logic [7:0] dout_r;
    prom_string_streamer #(.ADDR_W(4), .START_ADDR(0), .MSG_LEN(ML), .LOOP(LP)) dut (
      .clk(clk), .resetn(resetn), .start(start[g]), .abort(abort[g]),
      .busy(busy[g]), .done(done[g]), .bus(bus)
    );
    // Behavioural pROM: data registered on rom_ce, visible the following cycle.
    always @(posedge clk) if (bus.rom_ce) dout_r <= rom_mem[bus.rom_ad];
    assign bus.rom_dout = dout_r;
    assign bus.tx_ready = rdy[g];
    assign tv[g]   = bus.tx_valid;
    assign txd[g]  = bus.tx_data;
    assign rce[g]  = bus.rom_ce;
    assign rad[g]  = bus.rom_ad;
    assign oce[g]  = bus.rom_oce;
    assign rrst[g] = bus.rom_reset;
  end

  function automatic logic [7:0] exp_byte(input int a);
    if (a < 9) return 8'(8'h41 + a);
    else if (a < 15) return 8'(8'h50 + a - 9);
    else return 8'h00;
  endfunction

  task automatic push_msg(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_byte(i % 16));
  endtask

  task automatic clear_counts();
    for (int g = 0; g < 4; g++) begin hs_cnt[g] = 0; done_cnt[g] = 0; end
  endtask

  // Called at a negedge: a handshake seen now completes at the coming posedge.
  task automatic tick();
    for (int g = 0; g < 4; g++) begin
      if (resetn && tv[g] && rdy[g]) begin
        hs_cnt[g]++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sb_extra dut%0d: got %h, expected no byte", g, txd[g]);
        end else begin
          exp_b = exp_q.pop_front();
          if (txd[g] !== exp_b) begin
            failures++; $display("FAIL sb_byte dut%0d: got %h, expected %h", g, txd[g], exp_b);
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) if (done[g]) done_cnt[g]++;
  endtask

  task automatic run_until_idle(input int g, input int max);
    for (int i = 0; i < max && busy[g]; i++) tick();
    checks++;
    if (busy[g] !== 1'b0) begin failures++; $display("FAIL idle_timeout dut%0d: busy %b, expected 0", g, busy[g]); end
  endtask

  task automatic test_reset();
    checks += 8;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy[0]); end
    if (done[0] !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done[0]); end
    if (tv[0] !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", tv[0]); end
    if (txd[0] !== 8'h00) begin failures++; $display("FAIL rst_data: got %h expected 00", txd[0]); end
    if (rce[0] !== 1'b0) begin failures++; $display("FAIL rst_ce: got %b expected 0", rce[0]); end
    if (rad[0] !== 4'd0) begin failures++; $display("FAIL rst_ad: got %0d expected 0", rad[0]); end
    if (oce[0] !== 1'b1) begin failures++; $display("FAIL rst_oce: got %b expected 1", oce[0]); end
    if (rrst[0] !== 1'b0) begin failures++; $display("FAIL rst_romreset: got %b expected 0", rrst[0]); end
  endtask

  task automatic test_stream();
    clear_counts(); push_msg(15);
    rdy[0] = 1'b1; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    checks += 4;
    if (rce[0] !== 1'b1) begin failures++; $display("FAIL issue_ce: got %b expected 1", rce[0]); end
    if (rad[0] !== 4'd0) begin failures++; $display("FAIL issue_ad: got %0d expected 0", rad[0]); end
    if (busy[0] !== 1'b1) begin failures++; $display("FAIL issue_busy: got %b expected 1", busy[0]); end
    if (tv[0] !== 1'b0) begin failures++; $display("FAIL issue_valid: got %b expected 0", tv[0]); end
    tick();
    checks += 2;
    if (tv[0] !== 1'b0) begin failures++; $display("FAIL latch_valid: got %b expected 0", tv[0]); end
    if (rce[0] !== 1'b0) begin failures++; $display("FAIL latch_ce: got %b expected 0", rce[0]); end
    tick();
    checks++;
    if (tv[0] !== 1'b1) begin failures++; $display("FAIL latency_valid: got %b expected 1", tv[0]); end
    run_until_idle(0, 100);
    checks += 3;
    if (hs_cnt[0] !== 15) begin failures++; $display("FAIL stream_count: got %0d expected 15", hs_cnt[0]); end
    if (done_cnt[0] !== 1) begin failures++; $display("FAIL stream_done: got %0d expected 1", done_cnt[0]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL stream_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    clear_counts(); push_msg(15);
    rdy[0] = 1'b1; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    for (int i = 0; i < 40 && !(tv[0] && txd[0] == 8'h43); i++) tick();
    rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 3;
      if (tv[0] !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", tv[0]); end
      if (txd[0] !== 8'h43) begin failures++; $display("FAIL bp_data: got %h expected 43", txd[0]); end
      if (rce[0] !== 1'b0) begin failures++; $display("FAIL bp_ce: got %b expected 0", rce[0]); end
    end
    rdy[0] = 1'b1;
    run_until_idle(0, 100);
    checks += 2;
    if (hs_cnt[0] !== 15) begin failures++; $display("FAIL bp_count: got %0d expected 15", hs_cnt[0]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    clear_counts(); push_msg(3);
    rdy[0] = 1'b1; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    for (int i = 0; i < 40 && !(rce[0] && rad[0] == 4'd3); i++) tick();
    tick();
    abort[0] = 1'b1;
    tick();
    checks += 3;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL abl_busy: got %b expected 0", busy[0]); end
    if (tv[0] !== 1'b0) begin failures++; $display("FAIL abl_valid: got %b expected 0", tv[0]); end
    if (done[0] !== 1'b0) begin failures++; $display("FAIL abl_done: got %b expected 0", done[0]); end
    abort[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tv[0] !== 1'b0) begin failures++; $display("FAIL abl_novalid: got %b expected 0", tv[0]); end
    end
    checks += 2;
    if (hs_cnt[0] !== 3) begin failures++; $display("FAIL abl_count: got %0d expected 3", hs_cnt[0]); end
    if (done_cnt[0] !== 0) begin failures++; $display("FAIL abl_donecnt: got %0d expected 0", done_cnt[0]); end

    clear_counts(); push_msg(5);
    start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    for (int i = 0; i < 40 && !(tv[0] && txd[0] == 8'h45); i++) tick();
    rdy[0] = 1'b0; abort[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (tv[0] !== 1'b1) begin failures++; $display("FAIL abs_hold: got %b expected 1", tv[0]); end
      if (txd[0] !== 8'h45) begin failures++; $display("FAIL abs_data: got %h expected 45", txd[0]); end
    end
    rdy[0] = 1'b1;
    tick();
    checks += 2;
    if (done[0] !== 1'b1) begin failures++; $display("FAIL abs_done: got %b expected 1", done[0]); end
    if (tv[0] !== 1'b0) begin failures++; $display("FAIL abs_valid: got %b expected 0", tv[0]); end
    tick(); abort[0] = 1'b0;
    checks += 3;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL abs_idle: got %b expected 0", busy[0]); end
    if (hs_cnt[0] !== 5) begin failures++; $display("FAIL abs_count: got %0d expected 5", hs_cnt[0]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL abs_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_loop();
    bit dropped;
    dropped = 1'b0;
    clear_counts(); push_msg(15); push_msg(2);
    rdy[1] = 1'b1; start[1] = 1'b1;
    tick(); start[1] = 1'b0;
    for (int i = 0; i < 200 && hs_cnt[1] < 17; i++) begin
      tick();
      if (!busy[1]) dropped = 1'b1;
    end
    abort[1] = 1'b1;
    tick(); abort[1] = 1'b0;
    checks += 5;
    if (hs_cnt[1] !== 17) begin failures++; $display("FAIL loop_count: got %0d expected 17", hs_cnt[1]); end
    if (dropped !== 1'b0) begin failures++; $display("FAIL loop_busy: got drop %b expected 0", dropped); end
    if (done_cnt[1] !== 1) begin failures++; $display("FAIL loop_done: got %0d expected 1", done_cnt[1]); end
    if (busy[1] !== 1'b0) begin failures++; $display("FAIL loop_abort: got %b expected 0", busy[1]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL loop_left: got %0d expected 0", exp_q.size()); end
    rdy[1] = 1'b0;
  endtask

  task automatic test_boundary();
    clear_counts(); push_msg(16);
    rdy[2] = 1'b1; start[2] = 1'b1;
    tick(); start[2] = 1'b0;
    run_until_idle(2, 120);
    checks += 4;
    if (hs_cnt[2] !== 16) begin failures++; $display("FAIL len16_count: got %0d expected 16", hs_cnt[2]); end
    if (done_cnt[2] !== 1) begin failures++; $display("FAIL len16_done: got %0d expected 1", done_cnt[2]); end
    if (rad[2] !== 4'd15) begin failures++; $display("FAIL len16_ad: got %0d expected 15", rad[2]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL len16_left: got %0d expected 0", exp_q.size()); end

    clear_counts(); push_msg(1);
    rdy[3] = 1'b1; start[3] = 1'b1;
    tick(); start[3] = 1'b0;
    run_until_idle(3, 20);
    checks += 4;
    if (hs_cnt[3] !== 1) begin failures++; $display("FAIL len1_count: got %0d expected 1", hs_cnt[3]); end
    if (done_cnt[3] !== 1) begin failures++; $display("FAIL len1_done: got %0d expected 1", done_cnt[3]); end
    if (rad[3] !== 4'd0) begin failures++; $display("FAIL len1_ad: got %0d expected 0", rad[3]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL len1_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    rdy[0] = 1'b0; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    for (int i = 0; i < 10 && !tv[0]; i++) tick();
    checks++;
    if (txd[0] !== 8'h41) begin failures++; $display("FAIL rm_pending: got %h expected 41", txd[0]); end
    resetn = 1'b0;
    #1;
    checks += 3;
    if (tv[0] !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b expected 0", tv[0]); end
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b expected 0", busy[0]); end
    if (txd[0] !== 8'h00) begin failures++; $display("FAIL rm_data: got %h expected 00", txd[0]); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL rm_after: got %b expected 0", busy[0]); end
  endtask

  task automatic test_start_busy();
    clear_counts(); push_msg(15);
    rdy[0] = 1'b1; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    for (int i = 0; i < 40 && hs_cnt[0] < 5; i++) tick();
    start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    run_until_idle(0, 100);
    checks += 3;
    if (hs_cnt[0] !== 15) begin failures++; $display("FAIL sb_count: got %0d expected 15", hs_cnt[0]); end
    if (done_cnt[0] !== 1) begin failures++; $display("FAIL sb_done: got %0d expected 1", done_cnt[0]); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL sb_left: got %0d expected 0", exp_q.size()); end
    start[0] = 1'b1; abort[0] = 1'b1;
    tick(); start[0] = 1'b0; abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL start_abort: got %b expected 0", busy[0]); end
    tick();
    checks++;
    if (rce[0] !== 1'b0) begin failures++; $display("FAIL start_abort_ce: got %b expected 0", rce[0]); end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) rom_mem[i] = exp_byte(i);
    resetn = 1'b0; start = '0; abort = '0; rdy = '0;
    clear_counts();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    resetn = 1'b1;
    tick();
    test_stream();
    test_backpressure();
    test_abort();
    test_loop();
    test_boundary();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
